w0rm_core_fetch: RTL and testbench

- Instruction fetch stage of the W0RM core. Sits directly upstream of the decode stage.
- Owns the program counter and issues one read at a time to instruction memory over a req/ready address channel and an rvalid data channel.
- Presents each fetched instruction to decode on an inst_valid/decode_ready handshake.
- Accepts branch redirects from later stages, flushing any in-flight or held instruction.

---
 rtl/w0rm_core_fetch.sv | 123 ++++++++++++
 tb/tb_w0rm_core_fetch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/w0rm_core_fetch.sv
// W0RM core instruction fetch: owns the PC, issues one instruction-memory read at a
// time and presents the returned word to decode on a valid/ready handshake.
module w0rm_core_fetch #(
    parameter int                    INST_WIDTH   = 16,
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    PC_STEP      = INST_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_req,
    input  logic                  mem_ready,
    input  logic [INST_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid,
    output logic [INST_WIDTH-1:0] instruction,
    output logic                  inst_valid,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  decode_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   pc, pc_nxt;
    logic                    discard, discard_nxt;
    logic [INST_WIDTH-1:0]   inst_q, inst_nxt;
    logic [ADDR_WIDTH-1:0]   inst_pc_q, inst_pc_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            pc        <= RESET_VECTOR;
            discard   <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            discard   <= discard_nxt;
            inst_q    <= inst_nxt;
            inst_pc_q <= inst_pc_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        discard_nxt = discard;
        inst_nxt    = inst_q;
        inst_pc_nxt = inst_pc_q;

        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                if (mem_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    if (discard) begin
                        discard_nxt = 1'b0;
                        state_nxt   = S_REQ;
                    end else begin
                        inst_nxt    = mem_rdata;
                        inst_pc_nxt = pc;
                        state_nxt   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (decode_ready) begin
                    pc_nxt    = pc + ADDR_WIDTH'(PC_STEP);
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // A redirect wins over every normal transition, including a same-cycle decode transfer.
        if (branch_valid) begin
            pc_nxt      = branch_target;
            inst_nxt    = inst_q;
            inst_pc_nxt = inst_pc_q;
            case (state)
                S_IDLE: state_nxt = S_REQ;
                S_REQ: begin
                    if (mem_ready) begin
                        discard_nxt = 1'b1;
                        state_nxt   = S_WAIT;
                    end else begin
                        state_nxt   = S_IDLE;
                    end
                end
                S_WAIT: begin
                    // Only one response is ever outstanding, so a repeat redirect just retargets.
                    if (mem_rvalid) begin
                        discard_nxt = 1'b0;
                        state_nxt   = S_REQ;
                    end else begin
                        discard_nxt = 1'b1;
                        state_nxt   = S_WAIT;
                    end
                end
                S_HOLD: state_nxt = S_REQ;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign mem_req     = (state == S_REQ);
    assign mem_addr    = pc;
    assign inst_valid  = (state == S_HOLD);
    assign instruction = inst_q;
    assign inst_pc     = inst_pc_q;

endmodule

// File: tb/tb_w0rm_core_fetch.sv
// Directed bench for w0rm_core_fetch: a cycle table for the streaming/backpressure case
// plus hand-written redirect, wrap, stall and mid-transaction reset sequences.
module tb_w0rm_core_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic [15:0] instruction;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic        decode_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    w0rm_core_fetch dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .mem_addr     (mem_addr),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .instruction  (instruction),
        .inst_valid   (inst_valid),
        .inst_pc      (inst_pc),
        .decode_ready (decode_ready)
    );

    // Memory model: responds rsp_lat cycles after acceptance with 16'h1000 + addr.
    int          rsp_lat   = 1;
    logic        mem_pend  = 1'b0;
    int          mem_cnt   = 0;
    logic [31:0] mem_paddr = '0;

    always @(posedge clk) begin
        if (mem_pend) begin
            if (mem_cnt == 0) mem_pend <= 1'b0;
            else              mem_cnt  <= mem_cnt - 1;
        end
        if (mem_req && mem_ready) begin
            mem_pend  <= 1'b1;
            mem_cnt   <= rsp_lat - 1;
            mem_paddr <= mem_addr;
        end
    end

    assign mem_rvalid = mem_pend && (mem_cnt == 0);
    assign mem_rdata  = 16'h1000 + mem_paddr[15:0];

    typedef struct {
        logic        dr;
        logic        bv;
        logic [31:0] bt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [15:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tq[$];

    function automatic vec_t mk(logic dr, logic bv, logic [31:0] bt, logic er,
                                logic [31:0] ea, logic ev, logic [15:0] ei, logic [31:0] ep);
        vec_t v;
        v.dr = dr; v.bv = bv; v.bt = bt;
        v.e_req = er; v.e_addr = ea; v.e_vld = ev; v.e_inst = ei; v.e_pc = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic dr, input logic bv, input logic [31:0] bt);
        @(negedge clk);
        decode_ready  = dr;
        branch_valid  = bv;
        branch_target = bt;
        #1;
    endtask

    task automatic wait_valid(input string name, input int maxc);
        bit got;
        got = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            decode_ready = 1'b0;
            branch_valid = 1'b0;
            #1;
            if (inst_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: inst_valid timeout, got 0, expected 1", name);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " mem_req"},     32'(mem_req),     32'd0);
        chk({tag, " mem_addr"},    mem_addr,         32'h0);
        chk({tag, " inst_valid"},  32'(inst_valid),  32'd0);
        chk({tag, " instruction"}, 32'(instruction), 32'h0);
        chk({tag, " inst_pc"},     inst_pc,          32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        decode_ready  = 1'b0;
        branch_valid  = 1'b0;
        branch_target = '0;
        mem_ready     = 1'b1;

        // dr, bv, bt, exp req, exp addr, exp vld, exp inst, exp pc
        tq.push_back(mk(1, 0, 0,        0, 0,      0, 0,       0));      // IDLE
        tq.push_back(mk(1, 0, 0,        1, 0,      0, 0,       0));      // REQ 0
        tq.push_back(mk(1, 0, 0,        0, 0,      0, 0,       0));      // WAIT
        tq.push_back(mk(1, 0, 0,        0, 0,      1, 16'h1000, 0));     // HOLD
        tq.push_back(mk(1, 0, 0,        1, 2,      0, 0,       0));
        tq.push_back(mk(1, 0, 0,        0, 0,      0, 0,       0));
        tq.push_back(mk(0, 0, 0,        0, 0,      1, 16'h1002, 2));     // backpressure x5
        tq.push_back(mk(0, 0, 0,        0, 0,      1, 16'h1002, 2));
        tq.push_back(mk(0, 0, 0,        0, 0,      1, 16'h1002, 2));
        tq.push_back(mk(0, 0, 0,        0, 0,      1, 16'h1002, 2));
        tq.push_back(mk(0, 0, 0,        0, 0,      1, 16'h1002, 2));
        tq.push_back(mk(1, 0, 0,        0, 0,      1, 16'h1002, 2));
        tq.push_back(mk(1, 0, 0,        1, 4,      0, 0,       0));
        tq.push_back(mk(1, 0, 0,        0, 0,      0, 0,       0));
        tq.push_back(mk(1, 0, 0,        0, 0,      1, 16'h1004, 4));
        tq.push_back(mk(1, 0, 0,        1, 6,      0, 0,       0));
        tq.push_back(mk(1, 0, 0,        0, 0,      0, 0,       0));
        tq.push_back(mk(1, 1, 32'h200,  0, 0,      1, 16'h1006, 6));     // redirect in HOLD
        tq.push_back(mk(1, 0, 0,        1, 32'h200, 0, 0,      0));
        tq.push_back(mk(1, 0, 0,        0, 0,      0, 0,       0));
        tq.push_back(mk(1, 0, 0,        0, 0,      1, 16'h1200, 32'h200));

        repeat (3) @(posedge clk);
        #2;
        chk_reset_outputs("reset");
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        for (int i = 0; i < tq.size(); i++) begin
            step(tq[i].dr, tq[i].bv, tq[i].bt);
            chk($sformatf("row%0d mem_req", i), 32'(mem_req), 32'(tq[i].e_req));
            if (tq[i].e_req)
                chk($sformatf("row%0d mem_addr", i), mem_addr, tq[i].e_addr);
            chk($sformatf("row%0d inst_valid", i), 32'(inst_valid), 32'(tq[i].e_vld));
            if (tq[i].e_vld) begin
                chk($sformatf("row%0d instruction", i), 32'(instruction), 32'(tq[i].e_inst));
                chk($sformatf("row%0d inst_pc", i), inst_pc, tq[i].e_pc);
            end
        end

        // Redirect while waiting for a slow response, then a second redirect.
        rsp_lat = 3;
        step(1, 0, 0);
        chk("wr req", 32'(mem_req), 32'd1);
        chk("wr addr", mem_addr, 32'h202);
        step(0, 1, 32'h80);
        chk("wr wait req", 32'(mem_req), 32'd0);
        step(0, 1, 32'h100);
        chk("wr discard vld", 32'(inst_valid), 32'd0);
        step(0, 0, 0);
        chk("wr stale vld", 32'(inst_valid), 32'd0);
        step(0, 0, 0);
        chk("wr reissue req", 32'(mem_req), 32'd1);
        chk("wr reissue addr", mem_addr, 32'h100);
        wait_valid("wr", 10);
        chk("wr instruction", 32'(instruction), 32'h1100);
        chk("wr inst_pc", inst_pc, 32'h100);

        // Redirect in HOLD with decode_ready high, to the top of the address space.
        rsp_lat       = 1;
        decode_ready  = 1'b1;
        branch_valid  = 1'b1;
        branch_target = 32'hFFFF_FFFE;
        step(1, 0, 0);
        chk("hold redirect vld", 32'(inst_valid), 32'd0);
        chk("hold redirect req", 32'(mem_req), 32'd1);
        chk("hold redirect addr", mem_addr, 32'hFFFF_FFFE);
        wait_valid("wrap", 10);
        chk("wrap instruction", 32'(instruction), 32'h0FFE);
        chk("wrap inst_pc", inst_pc, 32'hFFFF_FFFE);
        decode_ready = 1'b1;

        // Stalled memory, then redirect while the request is still pending.
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0);
            mem_ready = 1'b0;
            chk($sformatf("stall%0d req", i), 32'(mem_req), 32'd1);
            chk($sformatf("stall%0d addr", i), mem_addr, 32'h0);
        end
        step(1, 1, 32'h40);
        chk("stall branch req", 32'(mem_req), 32'd1);
        step(1, 0, 0);
        chk("stall idle req", 32'(mem_req), 32'd0);
        rsp_lat = 3;
        step(1, 0, 0);
        mem_ready = 1'b1;
        chk("stall reissue req", 32'(mem_req), 32'd1);
        chk("stall reissue addr", mem_addr, 32'h40);

        // Asynchronous reset while a response is outstanding.
        step(1, 0, 0);
        chk("pre-reset wait req", 32'(mem_req), 32'd0);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async reset");
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        rsp_lat = 1;
        step(1, 0, 0);
        chk("post reset idle req", 32'(mem_req), 32'd0);
        step(1, 0, 0);
        chk("post reset req", 32'(mem_req), 32'd1);
        chk("post reset addr", mem_addr, 32'h0);
        wait_valid("post reset", 10);
        chk("post reset instruction", 32'(instruction), 32'h1000);
        chk("post reset inst_pc", inst_pc, 32'h0);
        step(1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
